// File: rtl/dequeue_agent_rr.sv
// Round-robin dequeue agent: picks an eligible output queue, pops its PIFO descriptor,
// then streams the packet out of that port's buffer until tlast, stalling on backpressure.
module dequeue_agent_rr #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PTR_W     = 3
) (
  input  logic                 axis_aclk,
  input  logic                 axis_reset,
  input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_empty,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_tlast,
  input  logic [NUM_PORTS-1:0] m_axis_port_ready,
  output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
  output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
  output logic [PTR_W-1:0]     m_axis_sel,
  output logic                 m_axis_busy,
  output logic [31:0]          pkt_sent_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StXfer
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [31:0]          cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic                 found;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     cand;
  logic                 rd_ok;
  logic                 last_rd;
  logic [PTR_W-1:0]     grant_inc;

  assign eligible = ~s_axis_pifo_empty & ~s_axis_buffer_empty & m_axis_port_ready;
  assign gnt_oh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;

  // The granted port alone decides transfer progress; other ports are ignored until tlast.
  assign rd_ok     = m_axis_port_ready[grant_q] & ~s_axis_buffer_empty[grant_q];
  assign last_rd   = rd_ok & s_axis_buffer_tlast[grant_q];
  assign grant_inc = (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  // First eligible port at or above rr_ptr, wrapping past the top port.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_PORTS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StXfer;
      end
      StXfer: begin
        if (last_rd) begin
          state_d  = StIdle;
          rr_ptr_d = grant_inc;
          cnt_d    = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are gated by reset so nothing leaves the block during the reset cycle itself.
  always_comb begin
    m_axis_ctl_pifo_out_en  = '0;
    m_axis_ctl_buffer_rd_en = '0;
    m_axis_busy             = 1'b0;
    if (!axis_reset) begin
      unique case (state_q)
        StPop: begin
          m_axis_ctl_pifo_out_en = gnt_oh;
          m_axis_busy            = 1'b1;
        end
        StXfer: begin
          m_axis_busy = 1'b1;
          if (rd_ok) begin
            m_axis_ctl_buffer_rd_en = gnt_oh;
          end
        end
        default: begin
          m_axis_busy = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis_sel   = grant_q;
  assign pkt_sent_cnt = cnt_q;

endmodule

// File: tb/tb_dequeue_agent_rr.sv
// Bench for dequeue_agent_rr: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural round-robin model.
module tb_dequeue_agent_rr;

  localparam int NP = 5;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pifo_empty, buf_empty, tlast, ready;
  logic [NP-1:0] pop_en, rd_en;
  logic [PW-1:0] sel;
  logic          busy;
  logic [31:0]   cnt;

  always #5 clk = ~clk;

  dequeue_agent_rr #(
    .NUM_PORTS(NP),
    .PTR_W    (PW)
  ) dut (
    .axis_aclk              (clk),
    .axis_reset             (rst),
    .s_axis_pifo_empty      (pifo_empty),
    .s_axis_buffer_empty    (buf_empty),
    .s_axis_buffer_tlast    (tlast),
    .m_axis_port_ready      (ready),
    .m_axis_ctl_pifo_out_en (pop_en),
    .m_axis_ctl_buffer_rd_en(rd_en),
    .m_axis_sel             (sel),
    .m_axis_busy            (busy),
    .pkt_sent_cnt           (cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: 0 = waiting for a port, 1 = descriptor pop, 2 = streaming words.
  int          m_state = 0;
  int          m_grant = 0;
  int          m_ptr   = 0;
  logic [31:0] m_cnt   = 0;
  bit          model_valid = 0;
  logic [NP-1:0] e_pop, e_rd;
  logic          e_busy;

  // Environment: descriptors per port and remaining word counts per buffered packet.
  int ndesc[NP];
  int pk[NP][$];
  bit rand_mode = 0;
  bit force_rst = 0;
  int lo_port = -1, lo_start = 0, lo_end = 0;
  int rst_at = -1;
  int tcyc = 0;

  logic [NP-1:0] tr_pop[64], tr_rd[64];
  logic          tr_busy[64];
  logic [PW-1:0] tr_sel[64];
  logic [31:0]   tr_cnt[64];
  int            pop_log[$];
  logic [31:0]   cnt_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    pk[p].push_back(len);
    ndesc[p]++;
  endtask

  task automatic env_clear();
    for (int p = 0; p < NP; p++) begin
      ndesc[p] = 0;
      pk[p].delete();
    end
    lo_port = -1;
    rst_at  = -1;
  endtask

  task automatic apply_inputs();
    rst = force_rst || (tcyc == rst_at) || (rand_mode && ($urandom % 200 == 0));
    for (int p = 0; p < NP; p++) begin
      bit st;
      st = rand_mode && ($urandom % 5 == 0);
      ready[p] = rand_mode ? ($urandom % 5 != 0) : 1'b1;
      if (p == lo_port && tcyc >= lo_start && tcyc < lo_end) ready[p] = 1'b0;
      pifo_empty[p] = (ndesc[p] == 0);
      buf_empty[p]  = (pk[p].size() == 0) || st;
      tlast[p]      = 1'b0;
      if (pk[p].size() != 0) tlast[p] = (pk[p][0] == 1);
    end
  endtask

  task automatic compare();
    e_pop  = '0;
    e_rd   = '0;
    e_busy = 1'b0;
    if (!rst && m_state != 0) begin
      e_busy = 1'b1;
      if (m_state == 1) e_pop[m_grant] = 1'b1;
      else if (ready[m_grant] && !buf_empty[m_grant]) e_rd[m_grant] = 1'b1;
    end
    check("pifo_out_en", 32'(pop_en), 32'(e_pop));
    check("buffer_rd_en", 32'(rd_en), 32'(e_rd));
    check("busy", 32'(busy), 32'(e_busy));
    if (model_valid) begin
      check("sel", 32'(sel), 32'(m_grant));
      check("pkt_sent_cnt", cnt, m_cnt);
    end
    if (tcyc < 64) begin
      tr_pop[tcyc]  = pop_en;
      tr_rd[tcyc]   = rd_en;
      tr_busy[tcyc] = busy;
      tr_sel[tcyc]  = sel;
      tr_cnt[tcyc]  = cnt;
    end
    if (pop_en != '0) begin
      pop_log.push_back(int'(sel));
      cnt_log.push_back(cnt);
    end
  endtask

  task automatic update();
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_grant = 0;
      m_cnt   = 0;
      model_valid = 1;
    end else if (m_state == 0) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (m_state == 0 && !pifo_empty[p] && !buf_empty[p] && ready[p]) begin
          m_grant = p;
          m_state = 1;
        end
      end
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (e_rd[m_grant] && tlast[m_grant]) begin
      m_state = 0;
      m_ptr   = (m_grant + 1) % NP;
      m_cnt   = m_cnt + 1;
    end
    for (int p = 0; p < NP; p++) begin
      if (e_pop[p] && ndesc[p] > 0) ndesc[p]--;
      if (e_rd[p] && pk[p].size() > 0) begin
        pk[p][0] = pk[p][0] - 1;
        if (pk[p][0] == 0) void'(pk[p].pop_front());
      end
    end
    if (rand_mode && ($urandom % 6 == 0)) begin
      int p;
      p = int'($urandom % NP);
      if (pk[p].size() < 4) add_pkt(p, 1 + int'($urandom % 4));
    end
    tcyc++;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    apply_inputs();
    #4;
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic run(input int n);
    tcyc = 0;
    pop_log.delete();
    cnt_log.delete();
    repeat (n) step();
  endtask

  task automatic do_reset();
    force_rst = 1;
    step();
    step();
    force_rst = 0;
  endtask

  int rd_sum;
  logic any_act;

  initial begin
    rst = 1'b1;
    pifo_empty = '1;
    buf_empty = '1;
    tlast = '0;
    ready = '0;
    env_clear();
    @(posedge clk);
    #1;

    // All ports loaded with one-word packets, port 0 twice.
    do_reset();
    env_clear();
    add_pkt(0, 1);
    add_pkt(0, 1);
    for (int p = 1; p < NP; p++) add_pkt(p, 1);
    run(24);
    check("rr_all_npops", pop_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pop_log.size()) check("rr_all_order", pop_log[i], i % 5);
      check("rr_all_read_after_pop", 32'(tr_rd[3 * i + 2]), 32'(1) << (i % 5));
    end
    if (cnt_log.size() >= 6) check("rr_all_cnt_after5", cnt_log[5], 5);
    check("rr_all_cnt_final", tr_cnt[23], 6);

    // Port 2 alone, three-word packet: latency pinned to literal cycles.
    do_reset();
    env_clear();
    add_pkt(2, 3);
    run(8);
    check("p2_idle_busy", 32'(tr_busy[0]), 0);
    check("p2_pop", 32'(tr_pop[1]), 32'b00100);
    check("p2_rd0", 32'(tr_rd[2]), 32'b00100);
    check("p2_rd1", 32'(tr_rd[3]), 32'b00100);
    check("p2_rd2", 32'(tr_rd[4]), 32'b00100);
    check("p2_rd_done", 32'(tr_rd[5]), 0);
    check("p2_busy_low", 32'(tr_busy[5]), 0);
    check("p2_cnt", tr_cnt[5], 1);

    // Port 3 five-word packet with ready[3] dropped for four cycles mid-packet.
    do_reset();
    env_clear();
    add_pkt(3, 5);
    lo_port = 3;
    lo_start = 4;
    lo_end = 8;
    run(14);
    for (int t = 4; t < 8; t++) begin
      check("p3_stall_rd", 32'(tr_rd[t]), 0);
      check("p3_stall_sel", 32'(tr_sel[t]), 3);
      check("p3_stall_busy", 32'(tr_busy[t]), 1);
    end
    check("p3_resume", 32'(tr_rd[8]), 32'b01000);
    rd_sum = 0;
    for (int t = 0; t < 14; t++) rd_sum += int'(tr_rd[t][3]);
    check("p3_words_read", rd_sum, 5);
    check("p3_cnt", tr_cnt[11], 1);

    // Bring rr_ptr to 2, then ports 1 and 4 compete.
    do_reset();
    env_clear();
    add_pkt(1, 1);
    run(4);
    add_pkt(1, 1);
    add_pkt(4, 1);
    run(8);
    check("rr_ptr2_npops", pop_log.size(), 2);
    if (pop_log.size() >= 2) begin
      check("rr_ptr2_first", pop_log[0], 4);
      check("rr_ptr2_second", pop_log[1], 1);
    end

    // Descriptor present but buffer empty: nothing may happen.
    do_reset();
    env_clear();
    ndesc[0] = 1;
    run(5);
    any_act = 1'b0;
    for (int t = 0; t < 5; t++) any_act |= tr_busy[t] | (|tr_pop[t]) | (|tr_rd[t]);
    check("noword_activity", 32'(any_act), 0);
    check("noword_npops", pop_log.size(), 0);

    // Reset during the second word of port 1.
    do_reset();
    env_clear();
    add_pkt(1, 3);
    rst_at = 3;
    run(5);
    check("rst_first_word", 32'(tr_rd[2]), 32'b00010);
    check("rst_cycle_rd", 32'(tr_rd[3]), 0);
    check("rst_after_rd", 32'(tr_rd[4]), 0);
    check("rst_after_pop", 32'(tr_pop[4]), 0);
    check("rst_after_busy", 32'(tr_busy[4]), 0);
    check("rst_after_cnt", tr_cnt[4], 0);
    check("rst_after_sel", 32'(tr_sel[4]), 0);
    env_clear();
    add_pkt(3, 1);
    add_pkt(0, 1);
    run(6);
    check("rst_rearb_npops", pop_log.size(), 2);
    if (pop_log.size() >= 1) check("rst_rearb_first", pop_log[0], 0);

    // Randomized traffic, stalls, backpressure and occasional resets.
    do_reset();
    env_clear();
    rand_mode = 1;
    run(4000);
    rand_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dequeue_agent_rr.md
DEQUEUE_AGENT_RR -- requirements
Module: dequeue_agent_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of output queues (ports 0-3 plus CPU port 4).
REQ-002 SHALL have parameter PTR_W, default 3, width of the port index; it SHALL satisfy 2^PTR_W >= NUM_PORTS.
REQ-003 SHALL have port axis_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port axis_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_axis_pifo_empty, input, NUM_PORTS, per-port PIFO holds no descriptor.
REQ-006 SHALL have port s_axis_buffer_empty, input, NUM_PORTS, per-port packet buffer holds no word.
REQ-007 SHALL have port s_axis_buffer_tlast, input, NUM_PORTS, last-word flag of each buffer's head word.
REQ-008 SHALL have port m_axis_port_ready, input, NUM_PORTS, downstream per-port tready.
REQ-009 SHALL have port m_axis_ctl_pifo_out_en, output, NUM_PORTS, one-hot PIFO pop pulse.
REQ-010 SHALL have port m_axis_ctl_buffer_rd_en, output, NUM_PORTS, one-hot buffer read strobe.
REQ-011 SHALL have port m_axis_sel, output, PTR_W, index of the currently granted port.
REQ-012 SHALL have port m_axis_busy, output, 1, high while a packet is being popped or transferred.
REQ-013 SHALL have port pkt_sent_cnt, output, 32, count of completed packet transfers.

Function
REQ-014 Port i SHALL be eligible when ~s_axis_pifo_empty[i] & ~s_axis_buffer_empty[i] & m_axis_port_ready[i].
REQ-015 The FSM SHALL have exactly three states: IDLE, POP and XFER.
REQ-016 In IDLE with at least one eligible port, the block SHALL register the grant as the first eligible port searching upward from rr_ptr with wrap at NUM_PORTS-1 to 0, drive m_axis_sel to it, and go to POP.
REQ-017 In IDLE with no eligible port, the FSM SHALL stay in IDLE and all strobes SHALL be 0.
REQ-018 In POP, m_axis_ctl_pifo_out_en[grant] SHALL be 1 for exactly one cycle, and the FSM SHALL then go to XFER.
REQ-019 In XFER, m_axis_ctl_buffer_rd_en[grant] SHALL equal m_axis_port_ready[grant] & ~s_axis_buffer_empty[grant], combinationally, and all other bits SHALL be 0.
REQ-020 In XFER, when the read strobe is asserted and s_axis_buffer_tlast[grant]=1, the block SHALL go to IDLE next cycle, set rr_ptr to grant+1 (wrapping to 0 after NUM_PORTS-1), and increment pkt_sent_cnt by 1, wrapping modulo 2^32.
REQ-021 A drop of ready or an empty buffer mid-packet SHALL stall XFER with no read strobe, hold the grant, and resume with no word lost or duplicated.
REQ-022 The grant SHALL NOT change before tlast is read; other ports' eligibility changes during POP and XFER SHALL be ignored.
REQ-023 Minimum latency SHALL be: eligibility seen in IDLE at cycle N, pop at N+1, first read at N+2; a one-word packet returns to IDLE at N+3.
REQ-024 A port that is the only eligible port SHALL be granted again on consecutive packets.
REQ-025 m_axis_busy SHALL be 1 in POP and XFER, and 0 in IDLE.
REQ-026 At most one bit of m_axis_ctl_pifo_out_en | m_axis_ctl_buffer_rd_en SHALL be set in any cycle.

Reset
REQ-027 When axis_reset=1 at a clock edge, the next state SHALL be IDLE, with rr_ptr=0, grant=0, m_axis_sel=0 and pkt_sent_cnt=0.
REQ-028 While axis_reset=1, all strobes and m_axis_busy SHALL be 0.
REQ-029 Reset asserted mid-XFER SHALL abandon the packet without completing it and SHALL NOT increment pkt_sent_cnt.
REQ-030 In the first cycle after reset release, the block SHALL evaluate eligibility from rr_ptr=0.

Verification
REQ-031 Bench SHALL cover: all 5 ports eligible, 1-word packets each -> grants in order 0,1,2,3,4,0, each pop followed by one read, pkt_sent_cnt=5 after the fifth tlast.
REQ-032 Bench SHALL cover: port 2 only, 3-word packet -> pop[2] at N+1, rd_en[2] for 3 cycles, tlast on the third, busy low at N+5, cnt=1.
REQ-033 Bench SHALL cover: port 3 mid-packet with ready[3] low for 4 cycles -> rd_en=0 for 4 cycles, grant held, all words read exactly once after ready returns.
REQ-034 Bench SHALL cover: ports 1 and 4 eligible with rr_ptr=2 -> port 4 granted first, then port 1.
REQ-035 Bench SHALL cover: pifo_empty=0 with buffer_empty=1 on port 0 -> no grant, all strobes 0, FSM stays in IDLE.
REQ-036 Bench SHALL cover: reset during the second word of port 1 -> strobes 0 next cycle, cnt=0, sel=0, and re-arbitration from port 0 after release.
